// File: rtl/join_fork_sched.sv
// join_fork_sched: joins one token from each of N_IN input places, then forks
// one token to each of N_OUT output places, each released as its consumer accepts.
module join_fork_sched #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic [N_IN-1:0]  i_valid,
    output logic [N_IN-1:0]  o_ready,
    output logic [N_OUT-1:0] o_valid,
    input  logic [N_OUT-1:0] i_ready,
    output logic             o_fire,
    output logic [CNT_W-1:0] o_fire_count,
    output logic             o_join_wait
);

    typedef enum logic {
        COLLECT = 1'b0,
        DIST    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  held_q, held_d;
    logic [N_OUT-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fire_q, fire;

    // COLLECT is exactly "pend is empty", so it gates firing.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        held_d  = held_q | (i_valid & ~held_q);
        pend_d  = pend_q & ~i_ready;
        count_d = count_q;
        state_d = state_q;
        fire    = (&held_q) && (state_q == COLLECT) && i_en && !i_flush;

        if (i_flush) begin
            held_d  = '0;
            pend_d  = '0;
            state_d = COLLECT;
        end else if (fire) begin
            held_d  = '0;
            pend_d  = '1;
            count_d = count_q + CNT_W'(1);
            state_d = DIST;
        end else if (state_q == DIST && pend_d == '0) begin
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            held_q  <= '0;
            pend_q  <= '0;
            count_q <= '0;
            fire_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            held_q  <= held_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            fire_q  <= fire;
        end
    end

    assign o_ready      = ~held_q;
    assign o_valid      = pend_q;
    assign o_fire       = fire_q;
    assign o_fire_count = count_q;
    assign o_join_wait  = (|held_q) & ~(&held_q);

endmodule
